// File: rtl/data_mem_arbiter_pkg.sv
// Shared state encoding and constants for data_mem_arbiter and its picker.
package data_mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    localparam int READ_EN_BIT            = 3;
    localparam int WRITE_EN_BIT           = 2;
    localparam int READ_CTRL_W            = 4;
    localparam int WRITE_CTRL_W           = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/data_mem_arbiter_picker.sv
// Combinational round-robin picker: first requester searching upward from last_grant+1, wrapping.
module round_robin_picker
    import data_mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic                 valid,
    output logic [IDX_W-1:0]     grant
);

    localparam int SUM_W = IDX_W + 2;

    logic [SUM_W-1:0] cand;

    // Visit every port once in priority order; the first hit wins.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = SUM_W'(last_grant) + SUM_W'(k);
            if (cand >= SUM_W'(NUM_PORTS)) begin
                cand = cand - SUM_W'(NUM_PORTS);
            end
            if (!valid && req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                grant = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sharing of one data-memory port among NUM_PORTS cores, stalling losers via busywait.
// Optional ACCESS timeout with sticky per-port ARB_ERROR flags: define DATA_MEM_ARB_TIMEOUT_EN.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [READ_CTRL_W*NUM_PORTS-1:0]  REQ_READ,
    input  logic [WRITE_CTRL_W*NUM_PORTS-1:0] REQ_WRITE,
    input  logic [32*NUM_PORTS-1:0]           REQ_ADDR,
    input  logic [32*NUM_PORTS-1:0]           REQ_WRITE_DATA,
    output logic [32*NUM_PORTS-1:0]           REQ_READ_DATA,
    output logic [NUM_PORTS-1:0]              REQ_BUSYWAIT,
    output logic [READ_CTRL_W-1:0]            MEM_READ,
    output logic [WRITE_CTRL_W-1:0]           MEM_WRITE,
    output logic [31:0]                       MEM_ADDR,
    output logic [31:0]                       MEM_WRITE_DATA,
    input  logic [31:0]                       MEM_READ_DATA,
    input  logic                              MEM_BUSYWAIT,
    output logic [NUM_PORTS-1:0]              ARB_ERROR
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t             state, next_state;
    logic [IDX_W-1:0]       grant, next_grant;
    logic [IDX_W-1:0]       last_grant, next_last_grant;
    logic [NUM_PORTS-1:0]   req;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_grant;
    logic                   timeout_hit;

    logic [READ_CTRL_W-1:0]  port_read  [NUM_PORTS];
    logic [WRITE_CTRL_W-1:0] port_write [NUM_PORTS];
    logic [31:0]             port_addr  [NUM_PORTS];
    logic [31:0]             port_wdata [NUM_PORTS];
    logic [31:0]             port_rdata [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign port_read[i]  = REQ_READ[i*READ_CTRL_W +: READ_CTRL_W];
        assign port_write[i] = REQ_WRITE[i*WRITE_CTRL_W +: WRITE_CTRL_W];
        assign port_addr[i]  = REQ_ADDR[i*32 +: 32];
        assign port_wdata[i] = REQ_WRITE_DATA[i*32 +: 32];
        assign req[i]        = port_read[i][READ_EN_BIT] | port_write[i][WRITE_EN_BIT];
        assign REQ_READ_DATA[i*32 +: 32] = port_rdata[i];
    end

    round_robin_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

`ifdef DATA_MEM_ARB_TIMEOUT_EN
    logic [15:0]          timer;
    logic [NUM_PORTS-1:0] error;

    // Timer counts ACCESS cycles already spent; it reads 0 in the first ACCESS cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            timer <= '0;
            error <= '0;
        end else begin
            timer <= (state == ACCESS) ? timer + 16'd1 : 16'd0;
            if (timeout_hit) begin
                error[grant] <= 1'b1;
            end
        end
    end

    assign ARB_ERROR = error;
`else
    wire unused_timeout = (TIMEOUT_CYCLES != 0);

    assign ARB_ERROR = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state      <= next_state;
            grant      <= next_grant;
            last_grant <= next_last_grant;
        end
    end

    // A reset cycle or a dropped request silences the memory command immediately.
    always_comb begin
        next_state      = state;
        next_grant      = grant;
        next_last_grant = last_grant;
        MEM_READ        = '0;
        MEM_WRITE       = '0;
        MEM_ADDR        = '0;
        MEM_WRITE_DATA  = '0;
        REQ_BUSYWAIT    = req;
        timeout_hit     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_rdata[i] = '0;
        end
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    next_state = ACCESS;
                    next_grant = pick_grant;
                end
            end
            ACCESS: begin
                if (req[grant] && !RESET) begin
                    MEM_READ       = port_read[grant];
                    MEM_WRITE      = port_write[grant];
                    MEM_ADDR       = port_addr[grant];
                    MEM_WRITE_DATA = port_wdata[grant];
                    if (!MEM_BUSYWAIT) begin
                        REQ_BUSYWAIT[grant] = 1'b0;
                        port_rdata[grant]   = MEM_READ_DATA;
                        next_state          = IDLE;
                        next_last_grant     = grant;
                    end
`ifdef DATA_MEM_ARB_TIMEOUT_EN
                    else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
                        timeout_hit         = 1'b1;
                        REQ_BUSYWAIT[grant] = 1'b0;
                        next_state          = IDLE;
                        next_last_grant     = grant;
                    end
`endif
                end else begin
                    next_state      = IDLE;
                    next_last_grant = grant;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table, directed sequences and random traffic vs a reference model.
module tb_data_mem_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic            CLK = 1'b0;
    logic            RESET;
    logic [4*N-1:0]  REQ_READ;
    logic [3*N-1:0]  REQ_WRITE;
    logic [32*N-1:0] REQ_ADDR;
    logic [32*N-1:0] REQ_WRITE_DATA;
    logic [32*N-1:0] REQ_READ_DATA;
    logic [N-1:0]    REQ_BUSYWAIT;
    logic [3:0]      MEM_READ;
    logic [2:0]      MEM_WRITE;
    logic [31:0]     MEM_ADDR;
    logic [31:0]     MEM_WRITE_DATA;
    logic [31:0]     MEM_READ_DATA;
    logic            MEM_BUSYWAIT;
    logic [N-1:0]    ARB_ERROR;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(
        .NUM_PORTS      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .REQ_READ       (REQ_READ),
        .REQ_WRITE      (REQ_WRITE),
        .REQ_ADDR       (REQ_ADDR),
        .REQ_WRITE_DATA (REQ_WRITE_DATA),
        .REQ_READ_DATA  (REQ_READ_DATA),
        .REQ_BUSYWAIT   (REQ_BUSYWAIT),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .MEM_READ_DATA  (MEM_READ_DATA),
        .MEM_BUSYWAIT   (MEM_BUSYWAIT),
        .ARB_ERROR      (ARB_ERROR)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [3:0]   rd0;
        logic [2:0]   wr0;
        logic [31:0]  addr0;
        logic         busy;
        logic [31:0]  rdata;
        logic [3:0]   expRead;
        logic [31:0]  expAddr;
        logic [N-1:0] expBusy;
        logic [31:0]  expRdata0;
    } vec_t;

    txn_t txq [N][$];
    int   grantLog[$];
    bit   actLog[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: who owns the memory, who owned it last, how long the current access has run.
    int           mOwner = -1;
    int           mLast = N - 1;
    int           mCycles = 0;
    logic [N-1:0] mErr = '0;

    int memCnt = 0;
    int memLat = 0;
    bit memStuck = 1'b0;
    bit memRandom = 1'b0;

    logic [N-1:0]    reqv;
    logic [3:0]      expRead;
    logic [2:0]      expWrite;
    logic [31:0]     expAddr;
    logic [31:0]     expWdata;
    logic [N-1:0]    expBusy;
    logic [32*N-1:0] expRdata;
    bit              expTimeout;

    task automatic checkVal(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic txn_t mkTxn(logic [3:0] rd, logic [2:0] wr, logic [31:0] addr, logic [31:0] wdata);
        txn_t t;
        t.rd = rd;
        t.wr = wr;
        t.addr = addr;
        t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t randTxn();
        txn_t t;
        t.addr  = $urandom;
        t.wdata = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            t.rd = {1'b1, 3'($urandom_range(0, 7))};
            t.wr = 3'b000;
        end else begin
            t.rd = 4'b0000;
            t.wr = {1'b1, 2'($urandom_range(0, 3))};
        end
        return t;
    endfunction

    task automatic driveNone();
        REQ_READ = '0;
        REQ_WRITE = '0;
        REQ_ADDR = '0;
        REQ_WRITE_DATA = '0;
    endtask

    task automatic applyStimulus();
        driveNone();
        for (int i = 0; i < N; i++) begin
            if (txq[i].size() > 0) begin
                REQ_READ[4*i +: 4]        = txq[i][0].rd;
                REQ_WRITE[3*i +: 3]       = txq[i][0].wr;
                REQ_ADDR[32*i +: 32]      = txq[i][0].addr;
                REQ_WRITE_DATA[32*i +: 32] = txq[i][0].wdata;
            end
        end
        if (memRandom) begin
            MEM_BUSYWAIT = ($urandom_range(0, 2) != 0);
        end else begin
            MEM_BUSYWAIT = memStuck || (memCnt < memLat);
        end
        MEM_READ_DATA = $urandom;
    endtask

    task automatic computeExpected();
        for (int i = 0; i < N; i++) begin
            reqv[i] = REQ_READ[4*i+3] | REQ_WRITE[3*i+2];
        end
        expBusy = reqv;
        expRead = '0;
        expWrite = '0;
        expAddr = '0;
        expWdata = '0;
        expRdata = '0;
        expTimeout = 1'b0;
        if (!RESET && mOwner >= 0 && reqv[mOwner]) begin
            expRead  = REQ_READ[4*mOwner +: 4];
            expWrite = REQ_WRITE[3*mOwner +: 3];
            expAddr  = REQ_ADDR[32*mOwner +: 32];
            expWdata = REQ_WRITE_DATA[32*mOwner +: 32];
            if (!MEM_BUSYWAIT) begin
                expBusy[mOwner] = 1'b0;
                expRdata[32*mOwner +: 32] = MEM_READ_DATA;
            end
`ifdef DATA_MEM_ARB_TIMEOUT_EN
            else if (mCycles == TO) begin
                expBusy[mOwner] = 1'b0;
                expTimeout = 1'b1;
            end
`endif
        end
    endtask

    task automatic checkOutput();
        checkVal("mem_read", MEM_READ, expRead);
        checkVal("mem_write", MEM_WRITE, expWrite);
        checkVal("mem_addr", MEM_ADDR, expAddr);
        checkVal("mem_wdata", MEM_WRITE_DATA, expWdata);
        checkVal("busywait", REQ_BUSYWAIT, expBusy);
        checkVal("read_data", REQ_READ_DATA, expRdata);
        checkVal("arb_error", ARB_ERROR, mErr);
    endtask

    // Advance one clock: core bookkeeping, memory latency counter and model update from pre-edge values.
    task automatic tick();
        bit found;
        int p;
        @(posedge CLK);
        for (int i = 0; i < N; i++) begin
            if (txq[i].size() > 0 && reqv[i]) begin
                if (!expBusy[i]) begin
                    grantLog.push_back(i);
                    void'(txq[i].pop_front());
                end else if (memRandom && $urandom_range(0, 49) == 0) begin
                    void'(txq[i].pop_front());
                end
            end
        end
        memCnt = (expRead[3] | expWrite[2]) ? memCnt + 1 : 0;
        if (RESET) begin
            mOwner = -1;
            mLast = N - 1;
            mErr = '0;
        end else if (mOwner < 0) begin
            found = 1'b0;
            for (int j = 1; j <= N; j++) begin
                p = (mLast + j) % N;
                if (!found && reqv[p]) begin
                    found = 1'b1;
                    mOwner = p;
                    mCycles = 1;
                end
            end
        end else if (!reqv[mOwner] || !MEM_BUSYWAIT || expTimeout) begin
            if (expTimeout) mErr[mOwner] = 1'b1;
            mLast = mOwner;
            mOwner = -1;
        end else begin
            mCycles++;
        end
        cyc++;
        #1;
    endtask

    task automatic evalCycle();
        applyStimulus();
        #1;
        computeExpected();
        checkOutput();
        actLog.push_back((MEM_READ != 4'b0000) || (MEM_WRITE != 3'b000));
    endtask

    task automatic step();
        evalCycle();
        tick();
    endtask

    function automatic bit queuesEmpty();
        for (int i = 0; i < N; i++) begin
            if (txq[i].size() > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic runUntilEmpty(input string name, input int budget);
        int n = 0;
        while (!queuesEmpty() && n < budget) begin
            step();
            n++;
        end
        total++;
        if (!queuesEmpty()) begin
            bad++;
            $display("[TB] FAIL %s timeout got=%0d cycles required<%0d", name, n, budget);
            for (int i = 0; i < N; i++) txq[i].delete();
        end
    endtask

    task automatic doReset();
        for (int i = 0; i < N; i++) txq[i].delete();
        memStuck = 1'b0;
        memRandom = 1'b0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        grantLog.delete();
        actLog.delete();
    endtask

    task automatic checkOrder(input string name, input int exp[$]);
        checkVal({name, "_count"}, grantLog.size(), exp.size());
        for (int k = 0; k < exp.size() && k < grantLog.size(); k++) begin
            checkVal($sformatf("%s_%0d", name, k), grantLog[k], exp[k]);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int expOrder[$];
        int first;
        int lastA;
        int gap;

        vecs[0] = '{4'b1010, 3'b000, 32'h10, 1'b0, 32'h1234_5678, 4'b0000, 32'h0,  4'b0001, 32'h0};
        vecs[1] = '{4'b1010, 3'b000, 32'h10, 1'b0, 32'h1234_5678, 4'b1010, 32'h10, 4'b0000, 32'h1234_5678};
        vecs[2] = '{4'b0000, 3'b000, 32'h0,  1'b0, 32'h1234_5678, 4'b0000, 32'h0,  4'b0000, 32'h0};
        vecs[3] = '{4'b0000, 3'b000, 32'h0,  1'b1, 32'h0BAD_0BAD, 4'b0000, 32'h0,  4'b0000, 32'h0};
        vecs[4] = '{4'b0000, 3'b101, 32'h20, 1'b1, 32'h5555_AAAA, 4'b0000, 32'h0,  4'b0001, 32'h0};
        vecs[5] = '{4'b0000, 3'b101, 32'h20, 1'b1, 32'h5555_AAAA, 4'b0000, 32'h20, 4'b0001, 32'h0};
        vecs[6] = '{4'b0000, 3'b101, 32'h20, 1'b0, 32'h5555_AAAA, 4'b0000, 32'h20, 4'b0000, 32'h5555_AAAA};
        vecs[7] = '{4'b0000, 3'b000, 32'h0,  1'b0, 32'h5555_AAAA, 4'b0000, 32'h0,  4'b0000, 32'h0};

        RESET = 1'b1;
        driveNone();
        MEM_BUSYWAIT = 1'b0;
        MEM_READ_DATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        doReset();

        evalCycle();
        checkVal("reset_mem_read", MEM_READ, 0);
        checkVal("reset_mem_addr", MEM_ADDR, 0);
        checkVal("reset_read_data", REQ_READ_DATA, 0);
        checkVal("reset_arb_error", ARB_ERROR, 0);
        tick();

        $display("[TB] vector table: single-port load and store");
        for (int v = 0; v < 8; v++) begin
            driveNone();
            REQ_READ[3:0] = vecs[v].rd0;
            REQ_WRITE[2:0] = vecs[v].wr0;
            REQ_ADDR[31:0] = vecs[v].addr0;
            REQ_WRITE_DATA[31:0] = 32'hDEAD_0000 + 32'(v);
            MEM_BUSYWAIT = vecs[v].busy;
            MEM_READ_DATA = vecs[v].rdata;
            #1;
            computeExpected();
            checkOutput();
            checkVal($sformatf("vec%0d_mem_read", v), MEM_READ, vecs[v].expRead);
            checkVal($sformatf("vec%0d_mem_addr", v), MEM_ADDR, vecs[v].expAddr);
            checkVal($sformatf("vec%0d_busywait", v), REQ_BUSYWAIT, vecs[v].expBusy);
            checkVal($sformatf("vec%0d_rdata0", v), REQ_READ_DATA[31:0], vecs[v].expRdata0);
            tick();
        end

        $display("[TB] contention: four ports, memory busy 3 cycles");
        doReset();
        memLat = 3;
        for (int i = 0; i < N; i++) txq[i].push_back(mkTxn(4'b1000 | 4'(i), 3'b000, 32'h100 + 32'(4*i), 32'h0));
        runUntilEmpty("contention", 200);
        expOrder = '{0, 1, 2, 3};
        checkOrder("contention_grant", expOrder);

        $display("[TB] round robin: ports 1 and 3 re-requesting");
        doReset();
        memLat = 1;
        txq[1].push_back(mkTxn(4'b1100, 3'b000, 32'h400, 32'h0));
        txq[1].push_back(mkTxn(4'b1001, 3'b000, 32'h404, 32'h0));
        txq[3].push_back(mkTxn(4'b0000, 3'b110, 32'h600, 32'h3333_0001));
        txq[3].push_back(mkTxn(4'b0000, 3'b111, 32'h604, 32'h3333_0002));
        runUntilEmpty("round_robin", 200);
        expOrder = '{1, 3, 1, 3};
        checkOrder("rr_grant", expOrder);

        $display("[TB] back-to-back store then load on port 2");
        doReset();
        memLat = 0;
        txq[2].push_back(mkTxn(4'b0000, 3'b110, 32'h200, 32'hCAFE_F00D));
        txq[2].push_back(mkTxn(4'b1100, 3'b000, 32'h200, 32'h0));
        runUntilEmpty("back_to_back", 50);
        first = -1;
        lastA = -1;
        gap = 0;
        foreach (actLog[k]) begin
            if (actLog[k]) begin
                if (first < 0) first = k;
                lastA = k;
            end
        end
        for (int k = 0; k < actLog.size(); k++) begin
            if (first >= 0 && k > first && k < lastA && !actLog[k]) gap++;
        end
        checkVal("b2b_idle_gap", gap, 1);

        $display("[TB] reset during port 1 access");
        doReset();
        memLat = 3;
        txq[1].push_back(mkTxn(4'b1010, 3'b000, 32'h500, 32'h0));
        step();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        grantLog.delete();
        txq[0].push_back(mkTxn(4'b1000, 3'b000, 32'h50, 32'h0));
        evalCycle();
        checkVal("rst_mem_read", MEM_READ, 0);
        checkVal("rst_mem_write", MEM_WRITE, 0);
        checkVal("rst_mem_addr", MEM_ADDR, 0);
        checkVal("rst_mem_wdata", MEM_WRITE_DATA, 0);
        tick();
        runUntilEmpty("after_reset", 100);
        expOrder = '{0, 1};
        checkOrder("rst_grant", expOrder);

`ifdef DATA_MEM_ARB_TIMEOUT_EN
        $display("[TB] timeout with memory stuck busy on port 2");
        doReset();
        memStuck = 1'b1;
        txq[2].push_back(mkTxn(4'b1010, 3'b000, 32'h220, 32'h0));
        txq[3].push_back(mkTxn(4'b1010, 3'b000, 32'h330, 32'h0));
        for (int n = 0; n < 40 && txq[2].size() > 0; n++) step();
        memStuck = 1'b0;
        memLat = 0;
        checkVal("timeout_arb_error", ARB_ERROR, 4'b0100);
        runUntilEmpty("timeout_drain", 100);
        expOrder = '{2, 3};
        checkOrder("timeout_grant", expOrder);
`endif

        $display("[TB] random traffic against reference model");
        doReset();
        memRandom = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (txq[i].size() == 0 && $urandom_range(0, 3) == 0) txq[i].push_back(randTxn());
            end
            step();
        end
        memRandom = 1'b0;
        memLat = 0;
        runUntilEmpty("random_drain", 400);
        actLog.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
